multicycle_controller: RTL and testbench

//  Main control FSM for the multicycle RV32I core. Decodes Instr from the datapath's instruction register and sequences it

---
 rtl/multicycle_controller.sv | 198 +++++++++++++++++++
 tb/tb_multicycle_controller.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle RV32I core: sequences one instruction at a time through its control steps.
// Latency: 3 cycles (branch, LUI), 4 (R, I, store, JAL, JALR, AUIPC), 5 (load); outputs are combinational from state.
// Backpressure: none; the FSM advances every cycle, and illegal encodings park it in HALT until reset.
// Ports: clk, rst_n (sync, active-low); Instr and ALU flags (Zero, CarryOut, Overflow, Sign) in;
//        datapath strobes (PCWrite, MemWrite, IRWrite, RegWrite), mux selects (AdrSrc, ResultSrc, ALUSrcA/B),
//        ALUControl, ImmSrc, and status (halted, retire) out.
module multicycle_controller #(
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] Instr,
  input  logic        Zero,
  input  logic        CarryOut,
  input  logic        Overflow,
  input  logic        Sign,
  output logic        PCWrite,
  output logic        AdrSrc,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [3:0]  ALUControl,
  output logic [2:0]  ImmSrc,
  output logic        halted,
  output logic        retire
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXEC_R, S_EXEC_I,
    S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_JALWB, S_LUI, S_AUIPC, S_HALT
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [3:0] ALU_ADD = 4'b0000, ALU_SUB = 4'b0001, ALU_AND = 4'b0010, ALU_OR  = 4'b0011,
                         ALU_XOR = 4'b0100, ALU_SLT = 4'b0101, ALU_SLTU = 4'b0110, ALU_SLL = 4'b0111,
                         ALU_SRL = 4'b1000, ALU_SRA = 4'b1001;

  state_t state, state_nxt;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       r_illegal;
  logic       br_illegal;
  logic       br_taken;
  logic [3:0] alu_dec;
  logic [2:0] imm_dec;

  assign opcode = Instr[6:0];
  assign funct3 = Instr[14:12];
  assign funct7 = Instr[31:25];

  // Only base-ISA funct7 values are legal; 0x20 qualifies just SUB and SRA.
  assign r_illegal  = ((funct7 != 7'h00) && (funct7 != 7'h20)) ||
                      ((funct7 == 7'h20) && (funct3 != 3'b000) && (funct3 != 3'b101));
  assign br_illegal = (funct3 == 3'b010) || (funct3 == 3'b011);

  // Flags come from A - B evaluated in the BRANCH cycle itself.
  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      3'b000:  br_taken = Zero;
      3'b001:  br_taken = ~Zero;
      3'b100:  br_taken = Sign ^ Overflow;
      3'b101:  br_taken = ~(Sign ^ Overflow);
      3'b110:  br_taken = ~CarryOut;
      3'b111:  br_taken = CarryOut;
      default: br_taken = 1'b0;
    endcase
  end

  // funct3 -> ALU op; Instr[30] selects SUB only for R-type, SRA for both R and I shifts.
  always_comb begin
    alu_dec = ALU_ADD;
    case (funct3)
      3'b000:  alu_dec = ((opcode == OP_R) && Instr[30]) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_dec = ALU_SLL;
      3'b010:  alu_dec = ALU_SLT;
      3'b011:  alu_dec = ALU_SLTU;
      3'b100:  alu_dec = ALU_XOR;
      3'b101:  alu_dec = Instr[30] ? ALU_SRA : ALU_SRL;
      3'b110:  alu_dec = ALU_OR;
      default: alu_dec = ALU_AND;
    endcase
  end

  always_comb begin
    imm_dec = 3'b000;
    case (opcode)
      OP_STORE:         imm_dec = 3'b001;
      OP_BR:            imm_dec = 3'b010;
      OP_JAL:           imm_dec = 3'b011;
      OP_LUI, OP_AUIPC: imm_dec = 3'b100;
      default:          imm_dec = 3'b000;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:  state_nxt = S_DECODE;
      S_DECODE: begin
        state_nxt = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
        case (opcode)
          OP_LOAD, OP_STORE: state_nxt = S_MEMADR;
          OP_R:     if (!r_illegal)  state_nxt = S_EXEC_R;
          OP_I:     state_nxt = S_EXEC_I;
          OP_BR:    if (!br_illegal) state_nxt = S_BRANCH;
          OP_JAL:   state_nxt = S_JAL;
          OP_JALR:  state_nxt = S_JALR;
          OP_LUI:   state_nxt = S_LUI;
          OP_AUIPC: state_nxt = S_AUIPC;
          default:  ;
        endcase
      end
      S_MEMADR:   state_nxt = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_nxt = S_MEMWB;
      S_EXEC_R,
      S_EXEC_I,
      S_JAL,
      S_AUIPC:    state_nxt = S_ALUWB;
      S_JALR:     state_nxt = S_JALWB;
      S_HALT:     state_nxt = S_HALT;
      default:    state_nxt = S_FETCH;   // MEMWB, MEMWRITE, ALUWB, BRANCH, JALWB, LUI
    endcase
  end

  // Output decode.
  always_comb begin
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUControl = ALU_ADD;
    ImmSrc     = imm_dec;
    halted     = 1'b0;
    retire     = 1'b0;
    case (state)
      S_FETCH:    begin IRWrite = 1'b1; PCWrite = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10; end
      S_DECODE:   begin ALUSrcA = 2'b01; ALUSrcB = 2'b01; end
      S_MEMADR:   begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; end
      S_MEMREAD:  AdrSrc = 1'b1;
      S_MEMWB:    begin ResultSrc = 2'b01; RegWrite = 1'b1; retire = 1'b1; end
      S_MEMWRITE: begin AdrSrc = 1'b1; MemWrite = 1'b1; retire = 1'b1; end
      S_EXEC_R:   begin ALUSrcA = 2'b10; ALUControl = alu_dec; end
      S_EXEC_I:   begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; ALUControl = alu_dec; end
      S_ALUWB:    begin RegWrite = 1'b1; retire = 1'b1; end
      S_BRANCH:   begin ALUSrcA = 2'b10; ALUControl = ALU_SUB; PCWrite = br_taken; retire = 1'b1; end
      // PC takes the target latched in ALUOut during DECODE while the ALU forms the link value.
      S_JAL:      begin ALUSrcA = 2'b01; ALUSrcB = 2'b10; PCWrite = 1'b1; end
      S_JALR:     begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; ResultSrc = 2'b10; PCWrite = 1'b1; end
      S_JALWB:    begin ALUSrcA = 2'b01; ALUSrcB = 2'b10; ResultSrc = 2'b10; RegWrite = 1'b1; retire = 1'b1; end
      S_LUI:      begin ResultSrc = 2'b11; RegWrite = 1'b1; retire = 1'b1; end
      S_AUIPC:    begin ALUSrcA = 2'b01; ALUSrcB = 2'b01; end
      S_HALT:     halted = 1'b1;
      default:    ;
    endcase
    // Reset blanks every output immediately, not just after the next edge.
    if (!rst_n) begin
      PCWrite    = 1'b0;
      AdrSrc     = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      RegWrite   = 1'b0;
      ResultSrc  = 2'b00;
      ALUSrcA    = 2'b00;
      ALUSrcB    = 2'b00;
      ALUControl = ALU_ADD;
      ImmSrc     = 3'b000;
      halted     = 1'b0;
      retire     = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] Instr = 32'h0;
  logic        Zero = 1'b0, CarryOut = 1'b0, Overflow = 1'b0, Sign = 1'b0;
  logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, halted, retire;
  logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB;
  logic [3:0]  ALUControl;
  logic [2:0]  ImmSrc;

  multicycle_controller #(.HALT_ON_ILLEGAL(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .Instr(Instr),
    .Zero(Zero), .CarryOut(CarryOut), .Overflow(Overflow), .Sign(Sign),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
    .ImmSrc(ImmSrc), .halted(halted), .retire(retire)
  );

  always #5 clk = ~clk;

  // {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUControl,ImmSrc,halted,retire}
  typedef logic [19:0] ctl_t;
  ctl_t  got;
  assign got = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB,
                ALUControl, ImmSrc, halted, retire};

  ctl_t  exp_q[$];
  string tag_q[$];
  int    total = 0;
  int    bad = 0;

  function automatic ctl_t ctl(input bit pcw, adr, mw, irw, rw, input logic [1:0] rs, sa, sb,
                               input logic [3:0] alu, input logic [2:0] imm, input bit h, ret);
    return {pcw, adr, mw, irw, rw, rs, sa, sb, alu, imm, h, ret};
  endfunction

  // Hand-written control words for the two states every instruction passes through.
  function automatic ctl_t c_fetch(input logic [2:0] imm);
    return ctl(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 4'b0000, imm, 0, 0);
  endfunction
  function automatic ctl_t c_decode(input logic [2:0] imm);
    return ctl(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 4'b0000, imm, 0, 0);
  endfunction

  localparam ctl_t ZERO = 20'h0;

  // One clock of stimulus; flags = {Zero,CarryOut,Overflow,Sign}. Expected word goes to the scoreboard.
  task automatic cyc(input logic r, input logic [31:0] ins, input logic [3:0] flags,
                     input ctl_t e, input string t);
    @(posedge clk);
    #1;
    rst_n = r;
    Instr = ins;
    {Zero, CarryOut, Overflow, Sign} = flags;
    exp_q.push_back(e);
    tag_q.push_back(t);
  endtask

  // Monitor: the DUT presents a control word every cycle; compare away from the active edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      ctl_t  e;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL %s: got=%05h want=%05h", t, got, e);
      end
    end
  end

  initial begin
    // Reset
    cyc(0, 32'h0, 4'h0, ZERO, "rst0");
    cyc(0, 32'h0, 4'h0, ZERO, "rst1");

    // add x0,x1,x2
    cyc(1, 32'h00208033, 4'h0, c_fetch(3'b000), "add.fetch");
    cyc(1, 32'h00208033, 4'h0, c_decode(3'b000), "add.decode");
    cyc(1, 32'h00208033, 4'h0, ctl(0,0,0,0,0, 2'b00, 2'b10, 2'b00, 4'b0000, 3'b000, 0,0), "add.exec");
    cyc(1, 32'h00208033, 4'h0, ctl(0,0,0,0,1, 2'b00, 2'b00, 2'b00, 4'b0000, 3'b000, 0,1), "add.aluwb");

    // sub
    cyc(1, 32'h40208033, 4'h0, c_fetch(3'b000), "sub.fetch");
    cyc(1, 32'h40208033, 4'h0, c_decode(3'b000), "sub.decode");
    cyc(1, 32'h40208033, 4'h0, ctl(0,0,0,0,0, 2'b00, 2'b10, 2'b00, 4'b0001, 3'b000, 0,0), "sub.exec");
    cyc(1, 32'h40208033, 4'h0, ctl(0,0,0,0,1, 2'b00, 2'b00, 2'b00, 4'b0000, 3'b000, 0,1), "sub.aluwb");

    // lw x2,4(x1)
    cyc(1, 32'h0040A103, 4'h0, c_fetch(3'b000), "lw.fetch");
    cyc(1, 32'h0040A103, 4'h0, c_decode(3'b000), "lw.decode");
    cyc(1, 32'h0040A103, 4'h0, ctl(0,0,0,0,0, 2'b00, 2'b10, 2'b01, 4'b0000, 3'b000, 0,0), "lw.memadr");
    cyc(1, 32'h0040A103, 4'h0, ctl(0,1,0,0,0, 2'b00, 2'b00, 2'b00, 4'b0000, 3'b000, 0,0), "lw.memread");
    cyc(1, 32'h0040A103, 4'h0, ctl(0,0,0,0,1, 2'b01, 2'b00, 2'b00, 4'b0000, 3'b000, 0,1), "lw.memwb");

    // sw x2,4(x1)
    cyc(1, 32'h0020A223, 4'h0, c_fetch(3'b001), "sw.fetch");
    cyc(1, 32'h0020A223, 4'h0, c_decode(3'b001), "sw.decode");
    cyc(1, 32'h0020A223, 4'h0, ctl(0,0,0,0,0, 2'b00, 2'b10, 2'b01, 4'b0000, 3'b001, 0,0), "sw.memadr");
    cyc(1, 32'h0020A223, 4'h0, ctl(0,1,1,0,0, 2'b00, 2'b00, 2'b00, 4'b0000, 3'b001, 0,1), "sw.memwrite");

    // blt, Sign=1 Overflow=0 -> taken
    cyc(1, 32'h0020C063, 4'b0001, c_fetch(3'b010), "blt.t.fetch");
    cyc(1, 32'h0020C063, 4'b0001, c_decode(3'b010), "blt.t.decode");
    cyc(1, 32'h0020C063, 4'b0001, ctl(1,0,0,0,0, 2'b00, 2'b10, 2'b00, 4'b0001, 3'b010, 0,1), "blt.t.branch");
    // blt, Sign=1 Overflow=1 -> not taken
    cyc(1, 32'h0020C063, 4'b0011, c_fetch(3'b010), "blt.n.fetch");
    cyc(1, 32'h0020C063, 4'b0011, c_decode(3'b010), "blt.n.decode");
    cyc(1, 32'h0020C063, 4'b0011, ctl(0,0,0,0,0, 2'b00, 2'b10, 2'b00, 4'b0001, 3'b010, 0,1), "blt.n.branch");
    // bltu, CarryOut=0 -> taken
    cyc(1, 32'h0020E063, 4'b0000, c_fetch(3'b010), "bltu.fetch");
    cyc(1, 32'h0020E063, 4'b0000, c_decode(3'b010), "bltu.decode");
    cyc(1, 32'h0020E063, 4'b0000, ctl(1,0,0,0,0, 2'b00, 2'b10, 2'b00, 4'b0001, 3'b010, 0,1), "bltu.branch");
    // bgeu, CarryOut=0 -> not taken
    cyc(1, 32'h0020F063, 4'b0000, c_fetch(3'b010), "bgeu.fetch");
    cyc(1, 32'h0020F063, 4'b0000, c_decode(3'b010), "bgeu.decode");
    cyc(1, 32'h0020F063, 4'b0000, ctl(0,0,0,0,0, 2'b00, 2'b10, 2'b00, 4'b0001, 3'b010, 0,1), "bgeu.branch");
    // beq, Zero=1 -> taken
    cyc(1, 32'h00208063, 4'b1000, c_fetch(3'b010), "beq.fetch");
    cyc(1, 32'h00208063, 4'b1000, c_decode(3'b010), "beq.decode");
    cyc(1, 32'h00208063, 4'b1000, ctl(1,0,0,0,0, 2'b00, 2'b10, 2'b00, 4'b0001, 3'b010, 0,1), "beq.branch");

    // lui x1,0x12345
    cyc(1, 32'h123450B7, 4'h0, c_fetch(3'b100), "lui.fetch");
    cyc(1, 32'h123450B7, 4'h0, c_decode(3'b100), "lui.decode");
    cyc(1, 32'h123450B7, 4'h0, ctl(0,0,0,0,1, 2'b11, 2'b00, 2'b00, 4'b0000, 3'b100, 0,1), "lui.wb");

    // jal x1,8
    cyc(1, 32'h008000EF, 4'h0, c_fetch(3'b011), "jal.fetch");
    cyc(1, 32'h008000EF, 4'h0, c_decode(3'b011), "jal.decode");
    cyc(1, 32'h008000EF, 4'h0, ctl(1,0,0,0,0, 2'b00, 2'b01, 2'b10, 4'b0000, 3'b011, 0,0), "jal.jal");
    cyc(1, 32'h008000EF, 4'h0, ctl(0,0,0,0,1, 2'b00, 2'b00, 2'b00, 4'b0000, 3'b011, 0,1), "jal.aluwb");

    // jalr x1,0(x1)
    cyc(1, 32'h000080E7, 4'h0, c_fetch(3'b000), "jalr.fetch");
    cyc(1, 32'h000080E7, 4'h0, c_decode(3'b000), "jalr.decode");
    cyc(1, 32'h000080E7, 4'h0, ctl(1,0,0,0,0, 2'b10, 2'b10, 2'b01, 4'b0000, 3'b000, 0,0), "jalr.jalr");
    cyc(1, 32'h000080E7, 4'h0, ctl(0,0,0,0,1, 2'b10, 2'b01, 2'b10, 4'b0000, 3'b000, 0,1), "jalr.jalwb");

    // srai x1,x1,3
    cyc(1, 32'h4030D093, 4'h0, c_fetch(3'b000), "srai.fetch");
    cyc(1, 32'h4030D093, 4'h0, c_decode(3'b000), "srai.decode");
    cyc(1, 32'h4030D093, 4'h0, ctl(0,0,0,0,0, 2'b00, 2'b10, 2'b01, 4'b1001, 3'b000, 0,0), "srai.exec");
    cyc(1, 32'h4030D093, 4'h0, ctl(0,0,0,0,1, 2'b00, 2'b00, 2'b00, 4'b0000, 3'b000, 0,1), "srai.aluwb");

    // Reset for 2 cycles during EXEC_R aborts the add; release resumes at FETCH.
    cyc(1, 32'h00208033, 4'h0, c_fetch(3'b000), "abort.fetch");
    cyc(1, 32'h00208033, 4'h0, c_decode(3'b000), "abort.decode");
    cyc(0, 32'h00208033, 4'h0, ZERO, "abort.rst0");
    cyc(0, 32'h00208033, 4'h0, ZERO, "abort.rst1");
    cyc(1, 32'h00208033, 4'h0, c_fetch(3'b000), "abort.refetch");
    cyc(1, 32'h00208033, 4'h0, c_decode(3'b000), "abort.redecode");
    cyc(1, 32'h00208033, 4'h0, ctl(0,0,0,0,0, 2'b00, 2'b10, 2'b00, 4'b0000, 3'b000, 0,0), "abort.exec");
    cyc(1, 32'h00208033, 4'h0, ctl(0,0,0,0,1, 2'b00, 2'b00, 2'b00, 4'b0000, 3'b000, 0,1), "abort.aluwb");

    // Illegal opcode: HALT after DECODE, sticky until reset.
    cyc(1, 32'hFFFFFFFF, 4'h0, c_fetch(3'b000), "ill.fetch");
    cyc(1, 32'hFFFFFFFF, 4'h0, c_decode(3'b000), "ill.decode");
    for (int i = 0; i < 20; i++)
      cyc(1, 32'hFFFFFFFF, 4'hF, ctl(0,0,0,0,0, 2'b00, 2'b00, 2'b00, 4'b0000, 3'b000, 1,0), "ill.halt");
    cyc(0, 32'hFFFFFFFF, 4'h0, ZERO, "ill.rst");
    cyc(1, 32'h123450B7, 4'h0, c_fetch(3'b100), "ill.refetch");
    cyc(1, 32'h123450B7, 4'h0, c_decode(3'b100), "ill.redecode");
    cyc(1, 32'h123450B7, 4'h0, ctl(0,0,0,0,1, 2'b11, 2'b00, 2'b00, 4'b0000, 3'b100, 0,1), "ill.lui");

    // Drain the scoreboard, bounded.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got=%0d entries left want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
